instr_seq_ctrl: RTL and testbench

- Multi-cycle fetch/decode/sequencing controller directly upstream of the ALU/regfile datapath.
- Fetches 16-bit instructions from a synchronous instruction ROM and decodes them into ALUOp, ALUSrc1/2, immediate, register addresses and RegWrite.
- Takes the ALU result back as regfile write data and uses take_branch/ovf to steer the PC.
- Replaces the VIO probe_out drive of the datapath controls.

---
 rtl/instr_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_instr_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_seq_ctrl.sv
// rtl/instr_seq_ctrl.sv - fetch/decode/sequencing controller for the ALU/regfile datapath
// Four-cycle FETCH/DECODE/EXEC/WB instruction loop with branch steering and overflow trap.
module instr_seq_ctrl #(
  parameter int         PC_W        = 8,
  parameter logic [3:0] ALUOP_ADD   = 4'h0,
  parameter bit         TRAP_ON_OVF = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic [15:0]     alu_result,
  input  logic            alu_ovf,
  input  logic            alu_take_branch,
  output logic [3:0]      ALUOp,
  output logic            ALUSrc1,
  output logic            ALUSrc2,
  output logic [15:0]     imm,
  output logic [2:0]      rd0_addr,
  output logic [2:0]      rd1_addr,
  output logic [2:0]      wr_addr,
  output logic [15:0]     wr_data,
  output logic            RegWrite,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            ovf_err
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     result_q, result_d;
  logic            take_q, take_d;
  logic            ovf_q, ovf_d;
  logic            ovf_err_q, ovf_err_d;

  logic [3:0]      opcode;
  logic [15:0]     off_sext;
  logic            writes;
  logic            is_branch;
  logic            trap;

  // Decode is purely a function of IR, so controls hold steady from EXEC through WB.
  always_comb begin
    opcode    = ir_q[15:12];
    off_sext  = {{10{ir_q[5]}}, ir_q[5:0]};
    ALUOp     = 4'h0;
    ALUSrc1   = 1'b0;
    ALUSrc2   = 1'b0;
    imm       = 16'h0000;
    rd0_addr  = 3'd0;
    rd1_addr  = 3'd0;
    wr_addr   = 3'd0;
    writes    = 1'b0;
    is_branch = 1'b0;
    if (!opcode[3]) begin
      ALUOp    = opcode;
      rd0_addr = ir_q[8:6];
      rd1_addr = ir_q[5:3];
      wr_addr  = ir_q[11:9];
      writes   = 1'b1;
    end else if (!opcode[2]) begin
      ALUOp    = opcode;
      ALUSrc2  = 1'b1;
      imm      = off_sext;
      rd0_addr = ir_q[8:6];
      wr_addr  = ir_q[11:9];
      writes   = 1'b1;
    end else if (!opcode[1]) begin
      ALUOp     = opcode;
      imm       = off_sext;
      rd0_addr  = ir_q[11:9];
      rd1_addr  = ir_q[8:6];
      is_branch = 1'b1;
    end else if (!opcode[0]) begin
      ALUOp    = ALUOP_ADD;
      ALUSrc1  = 1'b1;
      ALUSrc2  = 1'b1;
      imm      = {{7{ir_q[8]}}, ir_q[8:0]};
      wr_addr  = ir_q[11:9];
      writes   = 1'b1;
    end
  end

  assign trap      = TRAP_ON_OVF && writes && ovf_q;
  assign RegWrite  = (state_q == S_WB) && writes && !trap;
  assign halted    = (state_q == S_HALT);
  assign wr_data   = result_q;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign ovf_err   = ovf_err_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    result_d  = result_q;
    take_d    = take_q;
    ovf_d     = ovf_q;
    ovf_err_d = ovf_err_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          ovf_err_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = imem_data;
        state_d = (imem_data[15:12] == 4'hF) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_result;
        take_d   = alu_take_branch;
        ovf_d    = alu_ovf;
        state_d  = S_WB;
      end
      S_WB: begin
        if (trap) begin
          ovf_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          // Low PC_W bits of the sign-extended offset give the modular target directly.
          pc_d    = (is_branch && take_q) ? pc_q + PC_ONE + off_sext[PC_W-1:0] : pc_q + PC_ONE;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= 16'h0000;
      result_q  <= 16'h0000;
      take_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      result_q  <= result_d;
      take_q    <= take_d;
      ovf_q     <= ovf_d;
      ovf_err_q <= ovf_err_d;
    end
  end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb/tb_instr_seq_ctrl.sv - self-checking bench for instr_seq_ctrl
// Instruction-level reference model plus directed programs and randomized run.
module tb_instr_seq_ctrl;
  localparam int PC_W = 8;
  localparam int PC_MASK = (1 << PC_W) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data = 16'h0000;
  logic [15:0]     alu_result = 16'h0000;
  logic            alu_ovf = 1'b0;
  logic            alu_take_branch = 1'b0;
  logic [3:0]      ALUOp;
  logic            ALUSrc1, ALUSrc2;
  logic [15:0]     imm;
  logic [2:0]      rd0_addr, rd1_addr, wr_addr;
  logic [15:0]     wr_data;
  logic            RegWrite;
  logic [PC_W-1:0] pc;
  logic            halted, ovf_err;

  instr_seq_ctrl #(.PC_W(PC_W), .ALUOP_ADD(4'h0), .TRAP_ON_OVF(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_take_branch(alu_take_branch),
    .ALUOp(ALUOp), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .imm(imm),
    .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .wr_addr(wr_addr),
    .wr_data(wr_data), .RegWrite(RegWrite), .pc(pc),
    .halted(halted), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [256];
  always @(posedge clk) imem_data <= rom[imem_addr];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic        s1, s2;
    logic [15:0] imm;
    logic [2:0]  a0, a1, wa;
    logic        we, br;
  } dec_t;

  typedef struct { int pc; int wa; logic [15:0] wd; int cyc; } wr_t;
  wr_t wlog[$];

  // Reference model: mode 0 idle / 1 running / 2 halted; ph = cycle within the instruction.
  int          m_st, m_ph, m_pc, m_k;
  logic [15:0] m_ir, m_res;
  bit          m_ovf, m_tb, m_err;

  logic [15:0] res_tab [16];
  bit          ovf_tab [16];
  bit          tb_tab  [16];

  function automatic dec_t decode(input logic [15:0] ir);
    dec_t d = '0;
    int op = int'(ir[15:12]);
    int s6 = int'(ir[5:0]);
    int s9 = int'(ir[8:0]);
    if (s6 >= 32) s6 -= 64;
    if (s9 >= 256) s9 -= 512;
    if (op <= 7) begin
      d.op = ir[15:12]; d.a0 = ir[8:6]; d.a1 = ir[5:3]; d.wa = ir[11:9]; d.we = 1'b1;
    end else if (op <= 11) begin
      d.op = ir[15:12]; d.s2 = 1'b1; d.imm = 16'(s6); d.a0 = ir[8:6]; d.wa = ir[11:9]; d.we = 1'b1;
    end else if (op <= 13) begin
      d.op = ir[15:12]; d.imm = 16'(s6); d.a0 = ir[11:9]; d.a1 = ir[8:6]; d.br = 1'b1;
    end else if (op == 14) begin
      d.s1 = 1'b1; d.s2 = 1'b1; d.imm = 16'(s9); d.wa = ir[11:9]; d.we = 1'b1;
    end
    return d;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ph = 0; m_pc = 0; m_ir = 16'h0000; m_res = 16'h0000;
    m_ovf = 1'b0; m_tb = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_adv();
    dec_t d = decode(m_ir);
    if (m_st != 1) begin
      if (start) begin m_st = 1; m_ph = 0; m_pc = 0; m_err = 1'b0; end
    end else begin
      case (m_ph)
        0: m_ph = 1;
        1: begin
          m_ir = rom[m_pc];
          if (m_ir[15:12] == 4'hF) m_st = 2; else m_ph = 2;
        end
        2: begin
          m_res = alu_result; m_ovf = alu_ovf; m_tb = alu_take_branch; m_ph = 3;
        end
        default: begin
          if (d.we && m_ovf) begin
            m_err = 1'b1; m_st = 2;
          end else begin
            m_pc = (m_pc + 1 + ((d.br && m_tb) ? int'($signed(d.imm)) : 0)) & PC_MASK;
            m_ph = 0; m_k++;
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic compare_all();
    dec_t d = decode(m_ir);
    bit exp_we = (m_st == 1) && (m_ph == 3) && d.we && !m_ovf;
    chk("pc", 16'(pc), 16'(m_pc));
    chk("imem_addr", 16'(imem_addr), 16'(m_pc));
    chk("halted", 16'(halted), 16'(m_st == 2));
    chk("ovf_err", 16'(ovf_err), 16'(m_err));
    chk("RegWrite", 16'(RegWrite), 16'(exp_we));
    chk("wr_data", wr_data, m_res);
    chk("wr_addr", 16'(wr_addr), 16'(d.wa));
    chk("ALUOp", 16'(ALUOp), 16'(d.op));
    chk("ALUSrc1", 16'(ALUSrc1), 16'(d.s1));
    chk("ALUSrc2", 16'(ALUSrc2), 16'(d.s2));
    chk("imm", imm, d.imm);
    chk("rd0_addr", 16'(rd0_addr), 16'(d.a0));
    chk("rd1_addr", 16'(rd1_addr), 16'(d.a1));
    if (RegWrite === 1'b1) wlog.push_back('{int'(pc), int'(wr_addr), wr_data, cyc});
  endtask

  task automatic cycle(input bit rnd, input bit do_rst, input bit st);
    start = st;
    if (rnd) begin
      alu_result      = 16'($urandom);
      alu_ovf         = ($urandom_range(7) == 0);
      alu_take_branch = 1'($urandom_range(1));
    end else begin
      alu_result      = res_tab[m_k & 15];
      alu_ovf         = ovf_tab[m_k & 15];
      alu_take_branch = tb_tab[m_k & 15];
    end
    if (do_rst) begin reset = 1'b0; model_reset(); end
    else model_adv();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc++;
    compare_all();
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < 16; i++) begin res_tab[i] = 16'h0000; ovf_tab[i] = 1'b0; tb_tab[i] = 1'b0; end
  endtask

  task automatic run_to_halt(input int max_cyc);
    for (int i = 0; i < max_cyc && m_st != 2; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("halt_reached", 16'(halted), 16'd1);
  endtask

  task automatic run_prog(input int max_cyc);
    m_k = 0;
    wlog.delete();
    cycle(1'b0, 1'b0, 1'b1);
    run_to_halt(max_cyc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    model_reset();
    clear_tabs();
    @(negedge clk); @(negedge clk);
    chk("rst_pc", 16'(pc), 16'h0000);
    chk("rst_halted", 16'(halted), 16'h0000);
    chk("rst_regwrite", 16'(RegWrite), 16'h0000);
    chk("rst_ovf_err", 16'(ovf_err), 16'h0000);
    chk("rst_wr_data", wr_data, 16'h0000);
    compare_all();
    reset = 1'b1;

    // LI r1,5; LI r2,-3; ADD r3,r1,r2; LI r1,7; branch -2 (taken then not); HALT
    rom[0] = 16'hE205; rom[1] = 16'hE5FD; rom[2] = 16'h0650;
    rom[3] = 16'hE207; rom[4] = 16'hC2BE; rom[5] = 16'hF000;
    clear_tabs();
    res_tab[0] = 16'h0005; res_tab[1] = 16'hFFFD; res_tab[2] = 16'h0002;
    res_tab[3] = 16'h0007; res_tab[5] = 16'h0007; tb_tab[4] = 1'b1;
    run_prog(100);
    chk("a_write_count", 16'(wlog.size()), 16'd5);
    if (wlog.size() >= 5) begin
      chk("a_w0_addr", 16'(wlog[0].wa), 16'd1);
      chk("a_w0_data", wlog[0].wd, 16'h0005);
      chk("a_w1_addr", 16'(wlog[1].wa), 16'd2);
      chk("a_w1_data", wlog[1].wd, 16'hFFFD);
      chk("a_w2_addr", 16'(wlog[2].wa), 16'd3);
      chk("a_w2_data", wlog[2].wd, 16'h0002);
      chk("a_cadence1", 16'(wlog[1].cyc - wlog[0].cyc), 16'd4);
      chk("a_cadence2", 16'(wlog[2].cyc - wlog[1].cyc), 16'd4);
      chk("a_taken_target", 16'(wlog[4].pc), 16'd3);
    end
    chk("a_not_taken_pc", 16'(pc), 16'd5);

    // HALT at pc 2, then restart
    rom[0] = 16'hE205; rom[1] = 16'hE5FD; rom[2] = 16'hF000;
    clear_tabs();
    res_tab[0] = 16'h0005; res_tab[1] = 16'hFFFD;
    run_prog(100);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("b_pc_held", 16'(pc), 16'd2);
    chk("b_halted", 16'(halted), 16'd1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("b_restart_halted", 16'(halted), 16'd0);
    chk("b_restart_pc", 16'(pc), 16'd0);
    run_to_halt(100);

    // Branch back from 0 wraps to FF, then FF+1 wraps to 0
    rom[0] = 16'hC03E; rom[1] = 16'hF000; rom[255] = 16'hE801;
    clear_tabs();
    tb_tab[0] = 1'b1; res_tab[1] = 16'h0001;
    run_prog(100);
    chk("c_write_count", 16'(wlog.size()), 16'd1);
    if (wlog.size() >= 1) begin
      chk("c_wrap_pc", 16'(wlog[0].pc), 16'h00FF);
      chk("c_wrap_addr", 16'(wlog[0].wa), 16'd4);
    end
    chk("c_final_pc", 16'(pc), 16'd1);

    // Branch overflow ignored, then ADDI overflow traps
    rom[0] = 16'hE205; rom[1] = 16'hC201; rom[2] = 16'h8241; rom[3] = 16'hF000;
    clear_tabs();
    res_tab[0] = 16'h0005; ovf_tab[1] = 1'b1; res_tab[2] = 16'h8000; ovf_tab[2] = 1'b1;
    run_prog(100);
    chk("d_write_count", 16'(wlog.size()), 16'd1);
    chk("d_ovf_err", 16'(ovf_err), 16'd1);
    chk("d_pc_held", 16'(pc), 16'd2);
    cycle(1'b0, 1'b0, 1'b1);
    chk("d_err_cleared", 16'(ovf_err), 16'd0);
    chk("d_restart_pc", 16'(pc), 16'd0);

    // Reset in the middle of WB of LI r1,7
    cycle(1'b0, 1'b1, 1'b0);
    rom[0] = 16'hE207;
    clear_tabs();
    res_tab[0] = 16'h0007;
    m_k = 0;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("e_wb_regwrite", 16'(RegWrite), 16'd1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("e_async_regwrite", 16'(RegWrite), 16'd0);
    chk("e_async_pc", 16'(pc), 16'd0);
    chk("e_async_halted", 16'(halted), 16'd0);
    @(posedge clk); #1;
    chk("e_edge_regwrite", 16'(RegWrite), 16'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc++;
    compare_all();

    // Randomized programs, ALU responses, start pulses and resets
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    for (int i = 0; i < 4000; i++)
      cycle(1'b1, ($urandom_range(299) == 0), ($urandom_range(3) == 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
